// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage sitting in front of the RegisterFile.
// It accepts one instruction per handshake and drives the RF read addresses from it.
// The read operands are latched and offered to execute with opcode and destination.
// It also turns writeback requests into registered one-cycle RF write pulses.
// Optional feature: define WB_BYPASS_EN to forward an in-flight RF write into the operands.
module operand_fetch_stage #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FIELD_W = 5
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              instrValid,
  output logic              instrReady,
  input  logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] readAddressA,
  output logic [ADDR_W-1:0] readAddressB,
  input  logic [DATA_W-1:0] readDataA,
  input  logic [DATA_W-1:0] readDataB,
  output logic              opValid,
  input  logic              opReady,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [5:0]        opCode,
  output logic [ADDR_W-1:0] opDest,
  input  logic              wbValid,
  input  logic [ADDR_W-1:0] wbAddr,
  input  logic [DATA_W-1:0] wbData,
  output logic [ADDR_W-1:0] writeAddress,
  output logic              writeEn,
  output logic [DATA_W-1:0] writeData
);

  localparam int unsigned PadW   = ADDR_W - FIELD_W;
  localparam int unsigned RsLsb  = 21;
  localparam int unsigned RtLsb  = 16;
  localparam int unsigned RdLsb  = 11;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StHold
  } state_e;

  state_e state;

  // Instruction register: only the fields used after capture are kept. rs/rt live directly in
  // readAddressA/B, which are loaded at capture so they are stable for the whole READ cycle.
  logic [5:0]         irOpcode;
  logic [FIELD_W-1:0] irRd;

  logic [FIELD_W-1:0] instrRs;
  logic [FIELD_W-1:0] instrRt;
  logic [FIELD_W-1:0] instrRd;

  // Immediate/funct bits are not used by this stage.
  logic unusedInstrBits;
  assign unusedInstrBits = ^instr[RdLsb-1:0];

  assign instrRs = instr[RsLsb +: FIELD_W];
  assign instrRt = instr[RtLsb +: FIELD_W];
  assign instrRd = instr[RdLsb +: FIELD_W];

  // Ready is a pure decode of the state register, so it carries no combinational input path.
  assign instrReady = (state == StIdle);

  logic [DATA_W-1:0] fetchA;
  logic [DATA_W-1:0] fetchB;

`ifdef WB_BYPASS_EN
  // A write landing in the RF at the same edge we sample would be missed; take it directly.
  assign fetchA = (writeEn && (writeAddress == readAddressA)) ? writeData : readDataA;
  assign fetchB = (writeEn && (writeAddress == readAddressB)) ? writeData : readDataB;
`else
  assign fetchA = readDataA;
  assign fetchB = readDataB;
`endif

  // Fetch FSM: capture instruction, sample operands, hold bundle until execute takes it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= StIdle;
      irOpcode     <= '0;
      irRd         <= '0;
      readAddressA <= '0;
      readAddressB <= '0;
      opValid      <= 1'b0;
      opA          <= '0;
      opB          <= '0;
      opCode       <= '0;
      opDest       <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (instrValid) begin
            irOpcode     <= instr[31:26];
            irRd         <= instrRd;
            readAddressA <= {{PadW{1'b0}}, instrRs};
            readAddressB <= {{PadW{1'b0}}, instrRt};
            state        <= StRead;
          end
        end
        StRead: begin
          opA     <= fetchA;
          opB     <= fetchB;
          opCode  <= irOpcode;
          opDest  <= {{PadW{1'b0}}, irRd};
          opValid <= 1'b1;
          state   <= StHold;
        end
        StHold: begin
          if (opReady) begin
            opValid <= 1'b0;
            state   <= StIdle;
          end
        end
        default: begin
          opValid <= 1'b0;
          state   <= StIdle;
        end
      endcase
    end
  end

  // Writeback: one registered write pulse per sampled request; address/data hold when idle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      writeEn      <= 1'b0;
      writeAddress <= '0;
      writeData    <= '0;
    end else begin
      writeEn <= wbValid;
      if (wbValid) begin
        writeAddress <= wbAddr;
        writeData    <= wbData;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage with a behavioural RegisterFile attached.
module tb_operand_fetch_stage;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              instrValid = 1'b0;
  logic              instrReady;
  logic [DATA_W-1:0] instr = '0;
  logic [ADDR_W-1:0] readAddressA;
  logic [ADDR_W-1:0] readAddressB;
  logic [DATA_W-1:0] readDataA;
  logic [DATA_W-1:0] readDataB;
  logic              opValid;
  logic              opReady = 1'b0;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [5:0]        opCode;
  logic [ADDR_W-1:0] opDest;
  logic              wbValid = 1'b0;
  logic [ADDR_W-1:0] wbAddr = '0;
  logic [DATA_W-1:0] wbData = '0;
  logic [ADDR_W-1:0] writeAddress;
  logic              writeEn;
  logic [DATA_W-1:0] writeData;

  operand_fetch_stage dut (
    .clk          (clk),
    .resetN       (resetN),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .instr        (instr),
    .readAddressA (readAddressA),
    .readAddressB (readAddressB),
    .readDataA    (readDataA),
    .readDataB    (readDataB),
    .opValid      (opValid),
    .opReady      (opReady),
    .opA          (opA),
    .opB          (opB),
    .opCode       (opCode),
    .opDest       (opDest),
    .wbValid      (wbValid),
    .wbAddr       (wbAddr),
    .wbData       (wbData),
    .writeAddress (writeAddress),
    .writeEn      (writeEn),
    .writeData    (writeData)
  );

  always #5 clk = ~clk;

  // RegisterFile: combinational read, write committed at the clock edge.
  logic [DATA_W-1:0] rf [0:31];
  always @(posedge clk) if (writeEn) rf[writeAddress[4:0]] <= writeData;
  assign readDataA = rf[readAddressA[4:0]];
  assign readDataB = rf[readAddressB[4:0]];

  // Reference: architectural register contents as the bench intends them to be.
  logic [31:0] refRegs [0:31];
`ifdef WB_BYPASS_EN
  localparam bit BypassOn = 1'b1;
`else
  localparam bit BypassOn = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves wbValid low so callers may chain pulses back to back.
  task automatic wbPulse(input int addr, input logic [31:0] data);
    wbValid = 1'b1;
    wbAddr  = 16'(addr);
    wbData  = data;
    @(negedge clk);
    check("wbEn", 32'(writeEn), 32'd1);
    check("wbAddr", 32'(writeAddress), 32'(addr));
    check("wbData", writeData, data);
    refRegs[addr] = data;
    wbValid = 1'b0;
  endtask

  // Full fetch from IDLE through HOLD back to IDLE; optional writeback issued with the
  // instruction so its pulse lands in the READ cycle.
  task automatic fetch(input logic [31:0] word, input int holdCycles, input bit withWb,
                       input int wa, input logic [31:0] wd);
    int rs, rt, rd, opc;
    logic [31:0] expA, expB;
    rs  = int'((word >> 21) & 32'h1f);
    rt  = int'((word >> 16) & 32'h1f);
    rd  = int'((word >> 11) & 32'h1f);
    opc = int'(word >> 26);
    expA = (withWb && BypassOn && wa == rs) ? wd : refRegs[rs];
    expB = (withWb && BypassOn && wa == rt) ? wd : refRegs[rt];
    check("idleReady", 32'(instrReady), 32'd1);
    instrValid = 1'b1;
    instr      = word;
    if (withWb) begin
      wbValid = 1'b1;
      wbAddr  = 16'(wa);
      wbData  = wd;
    end
    @(negedge clk);
    check("readReady", 32'(instrReady), 32'd0);
    check("readAddrA", 32'(readAddressA), 32'(rs));
    check("readAddrB", 32'(readAddressB), 32'(rt));
    check("readOpValid", 32'(opValid), 32'd0);
    if (withWb) begin
      check("readWbEn", 32'(writeEn), 32'd1);
      refRegs[wa] = wd;
    end
    wbValid = 1'b0;
    // Offers made outside IDLE must be ignored.
    instrValid = 1'($urandom);
    instr      = $urandom;
    @(negedge clk);
    check("holdValid", 32'(opValid), 32'd1);
    check("holdOpA", opA, expA);
    check("holdOpB", opB, expB);
    check("holdOpCode", 32'(opCode), 32'(opc));
    check("holdOpDest", 32'(opDest), 32'(rd));
    check("holdReady", 32'(instrReady), 32'd0);
    for (int i = 0; i < holdCycles; i++) begin
      opReady = 1'b0;
      @(negedge clk);
      check("stallValid", 32'(opValid), 32'd1);
      check("stallOpA", opA, expA);
      check("stallOpB", opB, expB);
      check("stallReady", 32'(instrReady), 32'd0);
    end
    opReady = 1'b1;
    @(negedge clk);
    check("doneValid", 32'(opValid), 32'd0);
    check("doneReady", 32'(instrReady), 32'd1);
    check("doneAddrHold", 32'(readAddressA), 32'(rs));
    opReady    = 1'b0;
    instrValid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instrValid = 1'($urandom); instr = $urandom; opReady = 1'($urandom);
      wbValid = 1'($urandom); wbAddr = 16'($urandom); wbData = $urandom;
      check("rstOpValid", 32'(opValid), 32'd0);
      check("rstOpA", opA, 32'd0);
      check("rstOpB", opB, 32'd0);
      check("rstOpCode", 32'(opCode), 32'd0);
      check("rstOpDest", 32'(opDest), 32'd0);
      check("rstWrEn", 32'(writeEn), 32'd0);
      check("rstWrAddr", 32'(writeAddress), 32'd0);
      check("rstWrData", writeData, 32'd0);
      check("rstRdA", 32'(readAddressA), 32'd0);
      check("rstRdB", 32'(readAddressB), 32'd0);
    end
    instrValid = 1'b0; opReady = 1'b0; wbValid = 1'b0;
    resetN = 1'b1;
    @(negedge clk);
    check("postRstReady", 32'(instrReady), 32'd1);
    check("postRstValid", 32'(opValid), 32'd0);

    // Fill the register file with back-to-back writebacks.
    for (int r = 0; r < 32; r++) wbPulse(r, $urandom);
    wbPulse(3, 32'h5);
    wbPulse(4, 32'h6);
    @(negedge clk);
    check("wbIdleEn", 32'(writeEn), 32'd0);

    // Basic fetch with 4 cycles of backpressure.
    fetch(32'h0064_3800, 4, 1'b0, 0, 0);

    // Two consecutive writeback pulses, then hold, then read back.
    wbPulse(2, 32'h22);
    wbPulse(9, 32'h99);
    @(negedge clk);
    check("wbHoldEn", 32'(writeEn), 32'd0);
    check("wbHoldAddr", 32'(writeAddress), 32'd9);
    check("wbHoldData", writeData, 32'h99);
    fetch((32'h0a << 26) | (32'd2 << 21) | (32'd9 << 16) | (32'd1 << 11), 0, 1'b0, 0, 0);

    // Write to r3 landing in the READ cycle; then both operands hitting the same write.
    fetch((32'd3 << 21) | (32'd4 << 16) | (32'd5 << 11), 1, 1'b1, 3, 32'hAB);
    fetch((32'd8 << 21) | (32'd8 << 16) | (32'd8 << 11), 0, 1'b1, 8, 32'hCAFE_F00D);
    fetch((32'd3 << 21) | (32'd8 << 16), 0, 1'b0, 0, 0);

    // Random traffic.
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(1, 0) == 1) wbPulse(int'($urandom_range(31, 0)), $urandom);
      w = $urandom;
      fetch(w, int'($urandom_range(3, 0)), 1'($urandom), int'($urandom_range(31, 0)), $urandom);
    end

    // Reset during HOLD with a write pulse in flight.
    instrValid = 1'b1;
    instr      = (32'd5 << 21) | (32'd6 << 16) | (32'd7 << 11);
    @(negedge clk);
    instrValid = 1'b0;
    @(negedge clk);
    check("midHoldValid", 32'(opValid), 32'd1);
    wbValid = 1'b1; wbAddr = 16'd5; wbData = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    check("midWrEn", 32'(writeEn), 32'd1);
    wbValid = 1'b0;
    resetN  = 1'b0;
    #1;
    check("asyncOpValid", 32'(opValid), 32'd0);
    check("asyncWrEn", 32'(writeEn), 32'd0);
    check("asyncReady", 32'(instrReady), 32'd1);
    check("asyncWrAddr", 32'(writeAddress), 32'd0);
    check("asyncRdA", 32'(readAddressA), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("afterRstValid", 32'(opValid), 32'd0);
    check("afterRstReady", 32'(instrReady), 32'd1);
    // The discarded write must not have reached r5.
    fetch((32'd5 << 21) | (32'd6 << 16), 0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage of the multi-cycle processor; sits directly upstream of the RegisterFile.
- Accepts one 32-bit instruction per valid/ready handshake and drives the RegisterFile read addresses.
- Latches the two read operands and presents them, with opcode and destination, to the execute stage via a valid/ready handshake.
- Also owns the RegisterFile write port: it turns writeback requests from the later stage into registered single-cycle write pulses.

Parameters:
- ADDR_W, 16: width of RegisterFile address ports.
- DATA_W, 32: width of register data and instruction.
- FIELD_W, 5: width of the rs/rt/rd instruction fields; zero-extended to ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- instrValid  in  1  instruction offered
- instrReady  out  1  stage can accept an instruction
- instr  in  DATA_W  instruction word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11]
- readAddressA  out  ADDR_W  RegisterFile read address A (rs)
- readAddressB  out  ADDR_W  RegisterFile read address B (rt)
- readDataA  in  DATA_W  RegisterFile read data A (combinational read)
- readDataB  in  DATA_W  RegisterFile read data B
- opValid  out  1  operand bundle valid
- opReady  in  1  execute stage accepts bundle
- opA  out  DATA_W  operand A
- opB  out  DATA_W  operand B
- opCode  out  6  latched opcode
- opDest  out  ADDR_W  latched rd, zero-extended
- wbValid  in  1  writeback request
- wbAddr  in  ADDR_W  writeback register address
- wbData  in  DATA_W  writeback data
- writeAddress  out  ADDR_W  RegisterFile write address
- writeEn  out  1  RegisterFile write enable
- writeData  out  DATA_W  RegisterFile write data

Behaviour:
- Reset (resetN low, asynchronous):
  - state=IDLE; IR=0.
  - opValid=0, opA=opB=0, opCode=0, opDest=0.
  - writeEn=0, writeAddress=0, writeData=0.
  - readAddressA=readAddressB=0.
  - Reset mid-operation discards any captured instruction and any pending write.
- FSM states: IDLE, READ, HOLD.
  - IDLE: instrReady=1. When instrValid is high, capture instr into IR; next state READ.
  - READ: instrReady=0. readAddressA/B driven from IR rs/rt (registered, so stable the whole cycle). At the clock edge, opA<=readDataA, opB<=readDataB, opCode/opDest from IR, opValid<=1; next state HOLD.
  - HOLD: instrReady=0; outputs held stable. On opValid&opReady, opValid<=0 and next state IDLE.
- Outside READ, readAddressA/B hold their last value.
- Latency:
  - Instruction accepted at edge N → opValid high after edge N+1.
  - With opReady held high, throughput is one instruction per 3 cycles.
- Writeback path (always accepted; there is no wbReady):
  - wbValid sampled at edge M → writeEn=1 with writeAddress=wbAddr and writeData=wbData during cycle M..M+1.
  - writeEn is exactly one cycle long per wbValid cycle.
  - Back-to-back wbValid gives back-to-back pulses.
  - writeAddress/writeData hold their last value when writeEn=0.
- Field widths: rs/rt/rd are zero-extended from FIELD_W to ADDR_W; upper address bits are always 0.
- Simultaneous events:
  - wbValid while in any state has no effect on the FSM.
  - instrValid while not in IDLE is ignored; the instruction is not consumed.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: in READ, if writeEn=1 and writeAddress==readAddressA, opA takes writeData instead of readDataA. The same rule applies to opB with readAddressB. Both operands may bypass in the same cycle.
- Undefined: opA/opB always take readDataA/readDataB. Read-during-write results depend on the RegisterFile.

Test Plan:
- Reset: hold resetN=0 for 3 cycles with random inputs → all outputs 0, instrReady=1 after release.
- Basic fetch: RF preloaded with r3=0x5, r4=0x6; instr=0x00643800 (rs=3, rt=4, rd=7) accepted → readAddressA=3, readAddressB=4 in READ. Next cycle: opA=5, opB=6, opDest=7, opCode=0, opValid=1.
- Backpressure: opReady=0 for 4 cycles in HOLD → opA/opB/opValid unchanged and instrReady=0. Raise opReady → opValid=0 the next cycle, back in IDLE.
- Writeback pulse: wbValid=1 for 2 cycles with (addr 2, 0x22) then (addr 9, 0x99) → two consecutive one-cycle writeEn pulses with matching address/data. Read back r2=0x22 and r9=0x99 via a later fetch.
- Bypass (WB_BYPASS_EN defined): write to r3 with data 0xAB aligned so writeEn=1 in the READ cycle of an instruction with rs=3 → opA=0xAB. Undefined build → opA=old r3.
- Reset mid-operation: assert resetN low during HOLD and during a writeEn pulse → opValid and writeEn drop immediately (asynchronously), state IDLE.
